// File: rtl/slice_reduce_pipe_if.sv
// Handshake bundle for slice_reduce_pipe: beat source side and result sink side.
// master = the agent that feeds beats and consumes results; slave = the block itself.
interface slice_reduce_pipe_if #(
   parameter int DATA_W = 8
);
   localparam int G = DATA_W / 4;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] data;
   logic [1:0]        mode;
   logic              out_valid;
   logic              out_ready;
   logic [G-1:0]      nor_vec;
   logic [G-1:0]      mix_vec;

   modport master (
      output in_valid, data, mode, out_ready,
      input  in_ready, out_valid, nor_vec, mix_vec
   );

   modport slave (
      input  in_valid, data, mode, out_ready,
      output in_ready, out_valid, nor_vec, mix_vec
   );
endinterface

// File: rtl/slice_reduce_pipe.sv
// Per-nibble NOR4 / mode-selected combine, carried through a PIPE-deep valid/ready pipe (latency PIPE).
// Backpressure: global stall, in_ready = ~out_valid | out_ready; saturating count of delivered hit results.
module slice_reduce_pipe #(
   parameter int DATA_W = 8,
   parameter int PIPE   = 2,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   slice_reduce_pipe_if.slave bus,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  hit_cnt
);
   localparam int G = DATA_W / 4;

   logic         adv;
   logic [3:0]   grp;
   logic [G-1:0] nor_in;
   logic [G-1:0] mix_in;

   logic [PIPE-1:0] vld;
   logic [G-1:0]    nor_st [PIPE];
   logic [G-1:0]    mix_st [PIPE];

   // Results are computed on entry so the stages only carry 2*G bits each.
   always_comb begin
      grp    = '0;
      nor_in = '0;
      mix_in = '0;
      for (int g = 0; g < G; g++) begin
         grp       = bus.data[4*g +: 4];
         nor_in[g] = ~|grp;
         case (bus.mode)
            2'd0:    mix_in[g] = ~(grp[0] & grp[1]) & (grp[2] | grp[3]);
            2'd1:    mix_in[g] = grp[2] | grp[3];
            2'd2:    mix_in[g] = ^grp;
            default: mix_in[g] = &grp;
         endcase
      end
   end

   assign adv          = ~vld[PIPE-1] | bus.out_ready;
   assign bus.in_ready = adv;

   // Payload only moves behind a valid bit, so X on idle data never enters the pipe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         for (int i = 0; i < PIPE; i++) begin
            nor_st[i] <= '0;
            mix_st[i] <= '0;
         end
      end else if (adv) begin
         vld[0] <= bus.in_valid;
         if (bus.in_valid) begin
            nor_st[0] <= nor_in;
            mix_st[0] <= mix_in;
         end
         for (int i = 1; i < PIPE; i++) begin
            vld[i] <= vld[i-1];
            if (vld[i-1]) begin
               nor_st[i] <= nor_st[i-1];
               mix_st[i] <= mix_st[i-1];
            end
         end
      end
   end

   assign bus.out_valid = vld[PIPE-1];
   assign bus.nor_vec   = nor_st[PIPE-1];
   assign bus.mix_vec   = mix_st[PIPE-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt <= '0;
      end else if (clr_cnt) begin
         hit_cnt <= '0;
      end else if (bus.out_valid && bus.out_ready && (|bus.nor_vec) && (hit_cnt != {CNT_W{1'b1}})) begin
         hit_cnt <= hit_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_slice_reduce_pipe.sv
// Bench for slice_reduce_pipe: directed scenarios plus a randomized run against a queue model.
// dut_a uses defaults (8/2/8); dut_s shares its inputs with PIPE=3, CNT_W=2.
module tb_slice_reduce_pipe;
   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       clr_cnt = 1'b0;
   logic [7:0] hit_a;
   logic [1:0] hit_s;
   int         checks  = 0;
   int         errors  = 0;

   always #5 clk = ~clk;

   slice_reduce_pipe_if #(.DATA_W(8)) ifa ();
   slice_reduce_pipe_if #(.DATA_W(8)) ifs ();

   assign ifs.in_valid  = ifa.in_valid;
   assign ifs.data      = ifa.data;
   assign ifs.mode      = ifa.mode;
   assign ifs.out_ready = ifa.out_ready;

   slice_reduce_pipe #(.DATA_W(8), .PIPE(2), .CNT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa), .clr_cnt(clr_cnt), .hit_cnt(hit_a));
   slice_reduce_pipe #(.DATA_W(8), .PIPE(3), .CNT_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .bus(ifs), .clr_cnt(clr_cnt), .hit_cnt(hit_s));

   // Reference: {nor[1:0], mix[1:0]} from nibble values with plain arithmetic.
   function automatic logic [3:0] ref_res(input logic [7:0] d, input logic [1:0] m);
      logic [1:0] n;
      logic [1:0] x;
      int v;
      int pc;
      n = '0;
      x = '0;
      for (int g = 0; g < 2; g++) begin
         v  = int'((d >> (4*g)) & 8'h0F);
         pc = 0;
         for (int b = 0; b < 4; b++) pc += (v >> b) & 1;
         n[g] = (v == 0);
         case (m)
            2'd0:    x[g] = ((v % 4) != 3) && (v >= 4);
            2'd1:    x[g] = (v >= 4);
            2'd2:    x[g] = (pc % 2) == 1;
            default: x[g] = (v == 15);
         endcase
      end
      return {n, x};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ifa.in_valid = 1'b0;
      ifa.data     = 8'hxx;
      ifa.mode     = 2'd0;
   endtask

   task automatic test_reset();
      idle();
      ifa.out_ready = 1'b1;
      clr_cnt       = 1'b0;
      rst_n         = 1'b0;
      @(negedge clk);
      checks++;
      if (ifa.out_valid !== 1'b0 || ifs.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid got a=%b s=%b exp 0", ifa.out_valid, ifs.out_valid);
      end
      checks++;
      if (ifa.nor_vec !== 2'b00 || ifa.mix_vec !== 2'b00) begin
         errors++; $display("FAIL reset_vecs got nor=%b mix=%b exp 00/00", ifa.nor_vec, ifa.mix_vec);
      end
      checks++;
      if (hit_a !== 8'd0 || hit_s !== 2'd0) begin
         errors++; $display("FAIL reset_hit got a=%0d s=%0d exp 0", hit_a, hit_s);
      end
      checks++;
      if (ifa.in_ready !== 1'b1 || ifs.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got a=%b s=%b exp 1", ifa.in_ready, ifs.in_ready);
      end
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_basic();
      ifa.out_ready = 1'b1;
      ifa.in_valid  = 1'b1;
      ifa.data      = 8'h0F;
      ifa.mode      = 2'd0;
      tick();
      idle();
      @(negedge clk);
      checks++;
      if (ifa.out_valid !== 1'b0) begin
         errors++; $display("FAIL basic_early got out_valid=%b exp 0", ifa.out_valid);
      end
      tick();
      @(negedge clk);
      checks++;
      if (ifa.out_valid !== 1'b1 || ifa.nor_vec !== 2'b10 || ifa.mix_vec !== 2'b00 || hit_a !== 8'd0) begin
         errors++; $display("FAIL basic_result got v=%b nor=%b mix=%b hit=%0d exp 1/10/00/0",
                            ifa.out_valid, ifa.nor_vec, ifa.mix_vec, hit_a);
      end
      tick();
      @(negedge clk);
      checks++;
      if (ifa.out_valid !== 1'b0 || hit_a !== 8'd1) begin
         errors++; $display("FAIL basic_after got v=%b hit=%0d exp 0/1", ifa.out_valid, hit_a);
      end
      tick();
   endtask

   task automatic test_modes();
      logic [7:0] td [4];
      logic [1:0] tm [4];
      logic [1:0] tx [4];
      logic [1:0] tn [4];
      td[0] = 8'h41; tm[0] = 2'd1; tx[0] = 2'b10; tn[0] = 2'b00;
      td[1] = 8'h44; tm[1] = 2'd0; tx[1] = 2'b11; tn[1] = 2'b00;
      td[2] = 8'hC5; tm[2] = 2'd2; tx[2] = 2'b00; tn[2] = 2'b00;
      td[3] = 8'hFF; tm[3] = 2'd3; tx[3] = 2'b11; tn[3] = 2'b00;
      ifa.out_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         if (k < 4) begin
            ifa.in_valid = 1'b1; ifa.data = td[k]; ifa.mode = tm[k];
         end else begin
            idle();
         end
         @(negedge clk);
         if (k >= 2 && k < 6) begin
            checks++;
            if (ifa.out_valid !== 1'b1 || ifa.mix_vec !== tx[k-2] || ifa.nor_vec !== tn[k-2] || hit_a !== 8'd1) begin
               errors++; $display("FAIL mode_%0d got v=%b nor=%b mix=%b hit=%0d exp 1/%b/%b/1",
                                  k-2, ifa.out_valid, ifa.nor_vec, ifa.mix_vec, hit_a, tn[k-2], tx[k-2]);
            end
         end
         if (k == 6) begin
            checks++;
            if (ifa.out_valid !== 1'b0) begin
               errors++; $display("FAIL mode_drain got out_valid=%b exp 0", ifa.out_valid);
            end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      for (int k = 0; k < 11; k++) begin
         ifa.out_ready = !(k >= 2 && k <= 6);
         if (k <= 7) begin
            ifa.in_valid = 1'b1;
            ifa.mode     = 2'd0;
            ifa.data     = (k == 0) ? 8'h01 : (k == 1) ? 8'h10 : 8'h00;
         end else begin
            idle();
         end
         @(negedge clk);
         if (k >= 2 && k <= 6) begin
            checks++;
            if (ifa.in_ready !== 1'b0 || ifa.out_valid !== 1'b1 || ifa.nor_vec !== 2'b10 ||
                ifa.mix_vec !== 2'b00 || hit_a !== 8'd1) begin
               errors++; $display("FAIL bp_stall_%0d got rdy=%b v=%b nor=%b mix=%b hit=%0d exp 0/1/10/00/1",
                                  k, ifa.in_ready, ifa.out_valid, ifa.nor_vec, ifa.mix_vec, hit_a);
            end
         end
         if (k == 7) begin
            checks++;
            if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b1 || ifa.nor_vec !== 2'b10) begin
               errors++; $display("FAIL bp_release got rdy=%b v=%b nor=%b exp 1/1/10",
                                  ifa.in_ready, ifa.out_valid, ifa.nor_vec);
            end
         end
         if (k == 8 || k == 9) begin
            checks++;
            if (ifa.out_valid !== 1'b1 || ifa.nor_vec !== ((k == 8) ? 2'b01 : 2'b11) || hit_a !== 8'(k - 6)) begin
               errors++; $display("FAIL bp_order_%0d got v=%b nor=%b hit=%0d exp 1/%b/%0d",
                                  k, ifa.out_valid, ifa.nor_vec, hit_a, (k == 8) ? 2'b01 : 2'b11, k - 6);
            end
         end
         if (k == 10) begin
            checks++;
            if (ifa.out_valid !== 1'b0 || hit_a !== 8'd4) begin
               errors++; $display("FAIL bp_end got v=%b hit=%0d exp 0/4", ifa.out_valid, hit_a);
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_flight();
      ifa.out_ready = 1'b0;
      ifa.in_valid  = 1'b1;
      ifa.data      = 8'h00;
      ifa.mode      = 2'd0;
      repeat (2) tick();
      idle();
      @(negedge clk);
      checks++;
      if (ifa.out_valid !== 1'b1) begin
         errors++; $display("FAIL rstf_stalled got out_valid=%b exp 1", ifa.out_valid);
      end
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ifa.out_valid !== 1'b0 || ifs.out_valid !== 1'b0 || hit_a !== 8'd0 || hit_s !== 2'd0 || ifa.in_ready !== 1'b1) begin
         errors++; $display("FAIL rstf_async got va=%b vs=%b ha=%0d hs=%0d rdy=%b exp 0/0/0/0/1",
                            ifa.out_valid, ifs.out_valid, hit_a, hit_s, ifa.in_ready);
      end
      tick();
      rst_n         = 1'b1;
      ifa.out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++;
         if (ifa.out_valid !== 1'b0 || ifs.out_valid !== 1'b0) begin
            errors++; $display("FAIL rstf_stale_%0d got a=%b s=%b exp 0", k, ifa.out_valid, ifs.out_valid);
         end
         tick();
      end
   endtask

   task automatic test_clear();
      idle();
      ifa.out_ready = 1'b1;
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      for (int k = 0; k < 7; k++) begin
         if (k <= 2) begin
            ifa.in_valid = 1'b1; ifa.data = 8'h00; ifa.mode = 2'd1;
         end else begin
            idle();
         end
         clr_cnt = (k == 4);
         @(negedge clk);
         if (k == 0 || k == 3 || k == 5) begin
            checks++;
            if (hit_a !== ((k == 3) ? 8'd1 : 8'd0)) begin
               errors++; $display("FAIL clr_cnt_%0d got hit=%0d exp %0d", k, hit_a, (k == 3) ? 1 : 0);
            end
         end
         if (k == 4) begin
            checks++;
            if (ifa.out_valid !== 1'b1 || ifa.nor_vec !== 2'b11 || hit_a !== 8'd2) begin
               errors++; $display("FAIL clr_setup got v=%b nor=%b hit=%0d exp 1/11/2", ifa.out_valid, ifa.nor_vec, hit_a);
            end
         end
         tick();
      end
      clr_cnt = 1'b0;
   endtask

   task automatic test_saturation();
      int ea;
      int es;
      idle();
      ifa.out_ready = 1'b1;
      clr_cnt = 1'b1;
      repeat (2) tick();
      clr_cnt = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k < 5) begin
            ifa.in_valid = 1'b1; ifa.data = 8'h00; ifa.mode = 2'd2;
         end else begin
            idle();
         end
         @(negedge clk);
         ea = (k < 3) ? 0 : ((k - 2 > 5) ? 5 : k - 2);
         es = (k < 4) ? 0 : ((k - 3 > 3) ? 3 : k - 3);
         checks++;
         if (hit_s !== 2'(es) || hit_a !== 8'(ea)) begin
            errors++; $display("FAIL sat_%0d got hs=%0d ha=%0d exp %0d/%0d", k, hit_s, hit_a, es, ea);
         end
         if (k == 2 || k == 3) begin
            checks++;
            if (ifs.out_valid !== (k == 3)) begin
               errors++; $display("FAIL sat_latency_%0d got s_valid=%b exp %b", k, ifs.out_valid, k == 3);
            end
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [3:0] qa[$];
      logic [3:0] qs[$];
      int         ca;
      int         cs;
      logic       hold;
      logic       stall_a, stall_s;
      logic [3:0] prev_a, prev_s, got, exp;
      hold = 1'b0; stall_a = 1'b0; stall_s = 1'b0; prev_a = '0; prev_s = '0;
      idle();
      ifa.out_ready = 1'b1;
      clr_cnt = 1'b1;
      repeat (5) tick();
      clr_cnt = 1'b0;
      ca = 0; cs = 0;
      for (int k = 0; k < 600; k++) begin
         if (!hold) begin
            ifa.in_valid = (k < 590) && ($urandom_range(0, 3) != 0);
            ifa.data     = ifa.in_valid ? 8'($urandom) : 8'hxx;
            ifa.mode     = 2'($urandom);
         end
         ifa.out_ready = (k >= 590) || ($urandom_range(0, 2) != 0);
         clr_cnt       = (k < 590) && ($urandom_range(0, 31) == 0);
         @(negedge clk);

         checks++;
         if ($isunknown(ifa.out_valid) || ifa.in_ready !== (!ifa.out_valid || ifa.out_ready)) begin
            errors++; $display("FAIL rand_a_ready cyc %0d got v=%b rdy=%b", k, ifa.out_valid, ifa.in_ready);
         end
         checks++;
         if (hit_a !== 8'(ca)) begin
            errors++; $display("FAIL rand_a_hit cyc %0d got %0d exp %0d", k, hit_a, ca);
         end
         got = {ifa.nor_vec, ifa.mix_vec};
         if (stall_a) begin
            checks++;
            if (ifa.out_valid !== 1'b1 || got !== prev_a) begin
               errors++; $display("FAIL rand_a_hold cyc %0d got v=%b res=%h exp 1/%h", k, ifa.out_valid, got, prev_a);
            end
         end
         exp = '0;
         if (ifa.out_valid === 1'b1 && ifa.out_ready === 1'b1) begin
            checks++;
            if (qa.size() == 0) begin
               errors++; $display("FAIL rand_a_spurious cyc %0d got res=%h exp none", k, got);
            end else begin
               exp = qa.pop_front();
               if (got !== exp) begin
                  errors++; $display("FAIL rand_a_data cyc %0d got %h exp %h", k, got, exp);
               end
            end
         end
         if (clr_cnt) ca = 0;
         else if (exp[3:2] != 2'b00 && ca < 255) ca++;
         if (ifa.in_valid === 1'b1 && ifa.in_ready === 1'b1) qa.push_back(ref_res(ifa.data, ifa.mode));
         stall_a = (ifa.out_valid === 1'b1) && (ifa.out_ready === 1'b0);
         prev_a  = got;

         checks++;
         if ($isunknown(ifs.out_valid) || ifs.in_ready !== (!ifs.out_valid || ifs.out_ready)) begin
            errors++; $display("FAIL rand_s_ready cyc %0d got v=%b rdy=%b", k, ifs.out_valid, ifs.in_ready);
         end
         checks++;
         if (hit_s !== 2'(cs)) begin
            errors++; $display("FAIL rand_s_hit cyc %0d got %0d exp %0d", k, hit_s, cs);
         end
         got = {ifs.nor_vec, ifs.mix_vec};
         if (stall_s) begin
            checks++;
            if (ifs.out_valid !== 1'b1 || got !== prev_s) begin
               errors++; $display("FAIL rand_s_hold cyc %0d got v=%b res=%h exp 1/%h", k, ifs.out_valid, got, prev_s);
            end
         end
         exp = '0;
         if (ifs.out_valid === 1'b1 && ifs.out_ready === 1'b1) begin
            checks++;
            if (qs.size() == 0) begin
               errors++; $display("FAIL rand_s_spurious cyc %0d got res=%h exp none", k, got);
            end else begin
               exp = qs.pop_front();
               if (got !== exp) begin
                  errors++; $display("FAIL rand_s_data cyc %0d got %h exp %h", k, got, exp);
               end
            end
         end
         if (clr_cnt) cs = 0;
         else if (exp[3:2] != 2'b00 && cs < 3) cs++;
         if (ifs.in_valid === 1'b1 && ifs.in_ready === 1'b1) qs.push_back(ref_res(ifs.data, ifs.mode));
         stall_s = (ifs.out_valid === 1'b1) && (ifs.out_ready === 1'b0);
         prev_s  = got;

         checks++;
         if (qa.size() > 2 || qs.size() > 3) begin
            errors++; $display("FAIL rand_depth cyc %0d got a=%0d s=%0d exp <=2/<=3", k, qa.size(), qs.size());
         end
         hold = (ifa.in_valid === 1'b1) && (ifa.in_ready !== 1'b1);
         tick();
      end
      checks++;
      if (qa.size() != 0 || qs.size() != 0) begin
         errors++; $display("FAIL rand_lost got pending a=%0d s=%0d exp 0/0", qa.size(), qs.size());
      end
   endtask

   initial begin
      idle();
      ifa.out_ready = 1'b1;
      test_reset();
      test_basic();
      test_modes();
      test_backpressure();
      test_reset_flight();
      test_clear();
      test_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
